// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_ctrl
//  Description : Round-robin sequencer sharing one iterative multiplier among
//                NREQ requesters. Grants one request at a time, issues a start
//                pulse, waits for a fresh done, and returns the product tagged
//                with the requester id. A wait-cycle timeout produces an error
//                response when the multiplier never completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 2 * INWIDTH,
    parameter int NREQ     = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*INWIDTH-1:0]   req_a,
    input  logic [NREQ*INWIDTH-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [OUTWIDTH-1:0]       rsp_y,
    output logic                      rsp_err,
    output logic                      mul_start,
    output logic [INWIDTH-1:0]        mul_a,
    output logic [INWIDTH-1:0]        mul_b,
    input  logic [OUTWIDTH-1:0]       mul_y,
    input  logic                      mul_ready,
    output logic                      busy
);

    localparam int C_IDW = $clog2(NREQ);
    // One extra bit so TIMEOUT-1 always fits regardless of TIMEOUT value
    localparam int C_CW  = $clog2(TIMEOUT + 1);
    localparam logic [C_CW-1:0]  C_TMO_LAST = C_CW'(TIMEOUT - 1);
    localparam logic [C_IDW-1:0] C_ID_LAST  = C_IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [C_IDW-1:0]      ptr_q, ptr_d;
    logic [C_IDW-1:0]      id_q, id_d;
    logic [INWIDTH-1:0]    mul_a_q, mul_a_d;
    logic [INWIDTH-1:0]    mul_b_q, mul_b_d;
    logic [OUTWIDTH-1:0]   rsp_y_q, rsp_y_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [C_CW-1:0]       cnt_q, cnt_d;
    logic                  seen_low_q, seen_low_d;

    logic                  grant_valid;
    logic [C_IDW-1:0]      grant_idx;
    logic                  hi_found;
    logic [C_IDW-1:0]      hi_idx;
    logic [C_IDW-1:0]      any_idx;
    logic [INWIDTH-1:0]    sel_a;
    logic [INWIDTH-1:0]    sel_b;
    logic [NREQ-1:0]       grant_onehot;

    // Circular priority search: lowest valid index at/after the pointer,
    // otherwise the lowest valid index overall (wrap-around).
    always_comb begin
        hi_found    = 1'b0;
        hi_idx      = '0;
        any_idx     = '0;
        grant_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_valid = 1'b1;
                any_idx     = C_IDW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = C_IDW'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : any_idx;
    end

    // Operand mux and one-hot accept vector for the current winner
    always_comb begin
        sel_a        = '0;
        sel_b        = '0;
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == C_IDW'(i)) begin
                sel_a           = req_a[i*INWIDTH +: INWIDTH];
                sel_b           = req_b[i*INWIDTH +: INWIDTH];
                grant_onehot[i] = grant_valid;
            end
        end
    end

    // Sequencer next-state logic: accept, issue, wait for fresh done, respond
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_y_d    = rsp_y_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        seen_low_d = seen_low_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    id_d    = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                seen_low_d = 1'b0;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + C_CW'(1);
                if (!mul_ready) begin
                    seen_low_d = 1'b1;
                end
                // A ready level only counts once it has been seen low in this
                // op, so a done held over from the previous op is ignored.
                if (mul_ready && seen_low_q) begin
                    rsp_y_d   = mul_y;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == C_TMO_LAST) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == C_ID_LAST) ? '0 : id_q + C_IDW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_y_q    <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_y_q    <= rsp_y_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
        end
    end

    // Accept is only offered in IDLE and is forced low while reset is held
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant_onehot : '0;
    assign mul_start = (state_q == ST_ISSUE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
`default_nettype wire
